// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Shares one external multiplier between two requesters. One operation is
//   in flight at a time. When both requesters are valid, the one that was not
//   served last wins.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready, reqN_a/b  operand handshake for requester N (0/1)
//   rspN_valid/ready            result handshake for requester N
//   rsp_hi, rsp_lo              captured 2*WIDTH unsigned product
//   mul_a, mul_b, mul_en        drive to the shared multiplier
//   mul_hi, mul_lo              multiplier result, valid LATENCY cycles after mul_en
//   busy                        high whenever an operation is in progress
//
// state | meaning
// IDLE  | arbitrating, reqN_ready offered to the granted requester
// ISSUE | operands on mul_a/mul_b, mul_en pulsed
// WAIT  | counting down multiplier latency, result captured at count 1
// RESP  | rspN_valid to owner, held until owner's rspN_ready
module mult_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_hi,
    output logic [WIDTH-1:0] rsp_lo,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_en,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    state_t           state_q;
    logic             owner_q;
    logic             last_q;
    logic             mul_en_q;
    logic             busy_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic idle;
    logic grant1;
    logic rsp_take;

    assign idle = (state_q == IDLE);

    // On a tie, last_q == 1 means requester 1 was served last, so 0 wins.
    assign grant1 = req1_valid && (!req0_valid || !last_q);

    // Ready is combinational; gating with rst_n keeps it low while in reset.
    assign req0_ready = rst_n && idle && req0_valid && !grant1;
    assign req1_ready = rst_n && idle && grant1;

    assign rsp_take = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            mul_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        owner_q  <= grant1;
                        a_q      <= grant1 ? req1_a : req0_a;
                        b_q      <= grant1 ? req1_b : req0_b;
                        mul_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_en_q <= 1'b0;
                    cnt_q    <= LAT_LOAD;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        hi_q         <= mul_hi;
                        lo_q         <= mul_lo;
                        rsp0_valid_q <= !owner_q;
                        rsp1_valid_q <= owner_q;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        last_q       <= owner_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign mul_en     = mul_en_q;
    assign busy       = busy_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_hi     = hi_q;
    assign rsp_lo     = lo_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter
//   Two instances (LATENCY 1 and LATENCY 4) driven with random traffic and
//   checked every cycle against a transaction-timing reference model: an op
//   accepted in cycle t pulses mul_en at t+1 and responds from t+2+LATENCY
//   until the owner consumes it. A behavioural multiplier with matching
//   latency sits on each instance's mul_* ports.
module tb_mult_arbiter;

    logic clk;
    logic rst_n;

    logic        req0_valid [2];
    logic        req1_valid [2];
    logic        req0_ready [2];
    logic        req1_ready [2];
    logic [31:0] req0_a [2];
    logic [31:0] req0_b [2];
    logic [31:0] req1_a [2];
    logic [31:0] req1_b [2];
    logic        rsp0_valid [2];
    logic        rsp1_valid [2];
    logic        rsp0_ready [2];
    logic        rsp1_ready [2];
    logic [31:0] rsp_hi [2];
    logic [31:0] rsp_lo [2];
    logic [31:0] mul_a [2];
    logic [31:0] mul_b [2];
    logic        mul_en [2];
    logic [31:0] mul_hi [2];
    logic [31:0] mul_lo [2];
    logic        busy [2];

    int n_total = 0;
    int n_bad   = 0;

    mult_arbiter #(.WIDTH(32), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid[0]), .req1_valid(req1_valid[0]),
        .req0_ready(req0_ready[0]), .req1_ready(req1_ready[0]),
        .req0_a(req0_a[0]), .req0_b(req0_b[0]), .req1_a(req1_a[0]), .req1_b(req1_b[0]),
        .rsp0_valid(rsp0_valid[0]), .rsp1_valid(rsp1_valid[0]),
        .rsp0_ready(rsp0_ready[0]), .rsp1_ready(rsp1_ready[0]),
        .rsp_hi(rsp_hi[0]), .rsp_lo(rsp_lo[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_en(mul_en[0]),
        .mul_hi(mul_hi[0]), .mul_lo(mul_lo[0]), .busy(busy[0])
    );

    mult_arbiter #(.WIDTH(32), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid[1]), .req1_valid(req1_valid[1]),
        .req0_ready(req0_ready[1]), .req1_ready(req1_ready[1]),
        .req0_a(req0_a[1]), .req0_b(req0_b[1]), .req1_a(req1_a[1]), .req1_b(req1_b[1]),
        .rsp0_valid(rsp0_valid[1]), .rsp1_valid(rsp1_valid[1]),
        .rsp0_ready(rsp0_ready[1]), .rsp1_ready(rsp1_ready[1]),
        .rsp_hi(rsp_hi[1]), .rsp_lo(rsp_lo[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_en(mul_en[1]),
        .mul_hi(mul_hi[1]), .mul_lo(mul_lo[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Behavioural multiplier: result register loads a*b LATENCY cycles after
    // the mul_en cycle and holds it until the next operation lands.
    logic [14:0] sr_v [2];
    logic [63:0] sr_d [2][15];
    logic        tap_v [2];
    logic [63:0] tap_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            tap_v[i] = 1'b0;
            tap_d[i] = '0;
            if (lat_of(i) == 1) begin
                tap_v[i] = mul_en[i];
                tap_d[i] = 64'(mul_a[i]) * 64'(mul_b[i]);
            end else begin
                tap_v[i] = sr_v[i][lat_of(i)-2];
                tap_d[i] = sr_d[i][lat_of(i)-2];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) sr_v[i] <= '0;
            else        sr_v[i] <= {sr_v[i][13:0], mul_en[i]};
            sr_d[i][0] <= 64'(mul_a[i]) * 64'(mul_b[i]);
            for (int k = 1; k < 15; k++) sr_d[i][k] <= sr_d[i][k-1];
            if (tap_v[i]) {mul_hi[i], mul_lo[i]} <= tap_d[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic zero_check(input int i, input string where);
        chk($sformatf("d%0d_%s_ctl", i, where),
            64'({req0_ready[i], req1_ready[i], rsp0_valid[i], rsp1_valid[i], busy[i], mul_en[i]}), 64'd0);
        chk($sformatf("d%0d_%s_mulab", i, where), {mul_a[i], mul_b[i]}, 64'd0);
        chk($sformatf("d%0d_%s_rsp", i, where), {rsp_hi[i], rsp_lo[i]}, 64'd0);
    endtask

    // Reference model state, one set per instance; describes the current cycle.
    bit          m_busy [2];
    int          m_age [2];
    bit          m_owner [2];
    bit          m_last [2];
    bit          m_fresh [2];
    logic [31:0] m_a [2];
    logic [31:0] m_b [2];
    logic [63:0] m_prod [2];
    int          ops_done [2];
    bit          rec_en;
    int          own_seq [2][8];
    int          own_n [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit g;
            bit e_r0;
            bit e_r1;
            bit in_rsp;
            if (!rst_n) begin
                zero_check(i, "inrst");
                m_busy[i]  = 1'b0;
                m_age[i]   = 0;
                m_last[i]  = 1'b1;
                m_fresh[i] = 1'b1;
            end else begin
                g    = 1'b0;
                e_r0 = 1'b0;
                e_r1 = 1'b0;
                if (!m_busy[i]) begin
                    if (req0_valid[i] && req1_valid[i]) g = !m_last[i];
                    else                               g = req1_valid[i];
                    e_r0 = req0_valid[i] && !g;
                    e_r1 = req1_valid[i] && g;
                end
                in_rsp = m_busy[i] && (m_age[i] >= 2 + lat_of(i));
                chk($sformatf("d%0d_ready0", i), 64'(req0_ready[i]), 64'(e_r0));
                chk($sformatf("d%0d_ready1", i), 64'(req1_ready[i]), 64'(e_r1));
                chk($sformatf("d%0d_busy", i), 64'(busy[i]), 64'(m_busy[i]));
                chk($sformatf("d%0d_mul_en", i), 64'(mul_en[i]), 64'(m_busy[i] && m_age[i] == 1));
                chk($sformatf("d%0d_rsp0_valid", i), 64'(rsp0_valid[i]), 64'(in_rsp && !m_owner[i]));
                chk($sformatf("d%0d_rsp1_valid", i), 64'(rsp1_valid[i]), 64'(in_rsp && m_owner[i]));
                if (m_busy[i]) chk($sformatf("d%0d_mul_ab", i), {mul_a[i], mul_b[i]}, {m_a[i], m_b[i]});
                if (in_rsp)    chk($sformatf("d%0d_product", i), {rsp_hi[i], rsp_lo[i]}, m_prod[i]);
                if (m_fresh[i]) begin
                    chk($sformatf("d%0d_fresh_mulab", i), {mul_a[i], mul_b[i]}, 64'd0);
                    chk($sformatf("d%0d_fresh_rsp", i), {rsp_hi[i], rsp_lo[i]}, 64'd0);
                end

                if (!m_busy[i]) begin
                    if (e_r0 || e_r1) begin
                        m_busy[i]  = 1'b1;
                        m_age[i]   = 1;
                        m_owner[i] = e_r1;
                        m_a[i]     = e_r1 ? req1_a[i] : req0_a[i];
                        m_b[i]     = e_r1 ? req1_b[i] : req0_b[i];
                        m_prod[i]  = 64'(m_a[i]) * 64'(m_b[i]);
                        m_fresh[i] = 1'b0;
                        if (rec_en && own_n[i] < 8) begin
                            own_seq[i][own_n[i]] = int'(e_r1);
                            own_n[i]++;
                        end
                    end
                end else if (in_rsp && (m_owner[i] ? rsp1_ready[i] : rsp0_ready[i])) begin
                    m_busy[i] = 1'b0;
                    m_last[i] = m_owner[i];
                    ops_done[i]++;
                end else if (m_age[i] < 1000) begin
                    m_age[i]++;
                end
            end
        end
    end

    function automatic logic [31:0] pick_op();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'h3, 32'h5, 32'hFFFF_FFFF, 32'h8000_0000};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return $urandom;
    endfunction

    task automatic drive(input int pv, input int pr);
        for (int i = 0; i < 2; i++) begin
            req0_valid[i] = ($urandom_range(99) < pv);
            req1_valid[i] = ($urandom_range(99) < pv);
            req0_a[i] = pick_op();
            req0_b[i] = pick_op();
            req1_a[i] = pick_op();
            req1_b[i] = pick_op();
            rsp0_ready[i] = ($urandom_range(99) < pr);
            rsp1_ready[i] = ($urandom_range(99) < pr);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] dir_a [2];
        logic [31:0] dir_b [2];
        bit found;
        dir_a = '{32'h0000_0003, 32'hFFFF_FFFF};
        dir_b = '{32'h0000_0005, 32'hFFFF_FFFF};
        rec_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ops_done[i] = 0;
            own_n[i]    = 0;
            m_busy[i]   = 1'b0;
            m_age[i]    = 0;
            m_owner[i]  = 1'b0;
            m_last[i]   = 1'b1;
            m_fresh[i]  = 1'b1;
            m_a[i] = '0; m_b[i] = '0; m_prod[i] = '0;
        end

        // Reset with both requesters already valid: nothing may be offered.
        rst_n = 1'b0;
        drive(100, 100);
        #2;
        for (int i = 0; i < 2; i++) zero_check(i, "por");
        repeat (3) cycle();

        // Both valid continuously from reset: grants must alternate 0,1,0,1.
        rec_en = 1'b1;
        rst_n  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            drive(100, 100);
            cycle();
        end
        rec_en = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                chk($sformatf("d%0d_alt_grant%0d", i, k), 64'(own_seq[i][k]), 64'(k % 2));

        // Directed operands on requester 0 only: 3*5 and the all-ones square.
        for (int e = 0; e < 2; e++) begin
            for (int c = 0; c < 8; c++) begin
                drive(0, 100);
                for (int i = 0; i < 2; i++) begin
                    req0_valid[i] = 1'b1;
                    req0_a[i] = dir_a[e];
                    req0_b[i] = dir_b[e];
                end
                cycle();
            end
        end

        // Random traffic with varying pressure and response back-pressure.
        for (int c = 0; c < 200; c++) begin drive(80, 90); cycle(); end
        for (int c = 0; c < 200; c++) begin drive(50, 20); cycle(); end
        for (int c = 0; c < 200; c++) begin drive(90, 5);  cycle(); end

        // Reset pulse while the LATENCY=4 instance is in its wait phase.
        drive(0, 100);
        req1_valid[1] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            cycle();
            if (m_busy[1] && m_age[1] == 3) found = 1'b1;
        end
        chk("d1_reached_wait", 64'(found), 64'd1);
        #1;
        rst_n = 1'b0;
        req1_valid[1] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) zero_check(i, "midop_rst");
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) cycle();

        // Single requester-1 operation after reset on both instances.
        drive(0, 100);
        for (int i = 0; i < 2; i++) begin
            req1_valid[i] = 1'b1;
            req1_a[i] = 32'h1234_5678;
            req1_b[i] = 32'h9ABC_DEF0;
        end
        cycle();
        drive(0, 100);
        for (int c = 0; c < 12; c++) cycle();

        for (int c = 0; c < 200; c++) begin drive(70, 60); cycle(); end
        drive(0, 100);
        for (int c = 0; c < 20; c++) cycle();

        chk("d0_ops_done_enough", 64'(ops_done[0] >= 40), 64'd1);
        chk("d1_ops_done_enough", 64'(ops_done[1] >= 20), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
